// File: rtl/truth_table_scanner.sv
// Scans a 3-input combinational function over all 8 input combinations, captures its
// truth table, then streams the maxterm indices out through a valid/ready handshake.
module truth_table_scanner #(
    parameter int unsigned SETTLE = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       f_in,
    output logic [2:0] abc_out,
    output logic       busy,
    output logic       done,
    output logic [7:0] table_out,
    output logic [3:0] mt_count,
    output logic       mt_valid,
    input  logic       mt_ready,
    output logic [2:0] mt_index,
    output logic       mt_last
);

    typedef enum logic [1:0] {StIdle, StScan, StEmit, StDone} state_e;

    localparam logic [3:0] SettleCnt = 4'(SETTLE);

    state_e     state_q;
    logic [2:0] idx_q;
    logic [3:0] cnt_q;
    logic [3:0] p_q;
    logic [7:0] table_q;
    logic [3:0] count_q;
    logic [2:0] abc_q;
    logic       busy_q;
    logic       done_q;

    logic [7:0] zero_mask;
    logic       found;
    logic       above;
    logic [2:0] hit_idx;

    // Zero entries at or above the emit pointer; a shift by 8 empties the mask.
    always_comb begin
        zero_mask = ~table_q & (8'hFF << p_q);
        found     = 1'b0;
        hit_idx   = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (zero_mask[i]) begin
                found   = 1'b1;
                hit_idx = 3'(i);
            end
        end
        above = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (zero_mask[i] && (i > int'(hit_idx))) begin
                above = 1'b1;
            end
        end
    end

    always_comb begin
        mt_valid = (state_q == StEmit) && found;
        mt_index = mt_valid ? hit_idx : 3'd0;
        mt_last  = mt_valid && !above;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            idx_q   <= 3'd0;
            cnt_q   <= 4'd0;
            p_q     <= 4'd0;
            table_q <= 8'd0;
            count_q <= 4'd0;
            abc_q   <= 3'd0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        state_q <= StScan;
                        idx_q   <= 3'd0;
                        cnt_q   <= 4'd0;
                        table_q <= 8'd0;
                        count_q <= 4'd0;
                        abc_q   <= 3'd0;
                        busy_q  <= 1'b1;
                    end
                end
                StScan: begin
                    if (cnt_q == SettleCnt) begin
                        table_q[idx_q] <= f_in;
                        if (!f_in) begin
                            count_q <= count_q + 4'd1;
                        end
                        cnt_q <= 4'd0;
                        if (idx_q == 3'd7) begin
                            state_q <= StEmit;
                            p_q     <= 4'd0;
                            abc_q   <= 3'd0;
                        end else begin
                            idx_q <= idx_q + 3'd1;
                            abc_q <= idx_q + 3'd1;
                        end
                    end else begin
                        cnt_q <= cnt_q + 4'd1;
                    end
                end
                StEmit: begin
                    if (!found) begin
                        state_q <= StDone;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else if (mt_ready) begin
                        p_q <= {1'b0, hit_idx} + 4'd1;
                        if (!above) begin
                            state_q <= StDone;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                    done_q  <= 1'b0;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign abc_out   = abc_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign table_out = table_q;
    assign mt_count  = count_q;

endmodule

// File: tb/tb_truth_table_scanner.sv
// Bench for truth_table_scanner: two instances (SETTLE=1 and SETTLE=3) driven with
// random functions and random handshake back-pressure, checked against a maxterm-list model.
module tb_truth_table_scanner;

    int unsigned total;
    int unsigned bad;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset;
    logic       start;
    logic       ready;
    logic       sel;
    logic [7:0] func;

    logic       start1, start3;
    logic       f1, f3;
    logic [2:0] abc1, abc3, idx1, idx3;
    logic       busy1, busy3, done1, done3, valid1, valid3, last1, last3;
    logic [7:0] tab1, tab3;
    logic [3:0] cnt1, cnt3;

    assign start1 = start && !sel;
    assign start3 = start && sel;
    assign f1 = func[abc1];
    assign f3 = func[abc3];

    truth_table_scanner #(.SETTLE(1)) u_dut1 (
        .clk(clk), .reset(reset), .start(start1), .f_in(f1), .abc_out(abc1), .busy(busy1),
        .done(done1), .table_out(tab1), .mt_count(cnt1), .mt_valid(valid1),
        .mt_ready(ready), .mt_index(idx1), .mt_last(last1)
    );

    truth_table_scanner #(.SETTLE(3)) u_dut3 (
        .clk(clk), .reset(reset), .start(start3), .f_in(f3), .abc_out(abc3), .busy(busy3),
        .done(done3), .table_out(tab3), .mt_count(cnt3), .mt_valid(valid3),
        .mt_ready(ready), .mt_index(idx3), .mt_last(last3)
    );

    logic [2:0] o_abc, o_idx;
    logic       o_busy, o_done, o_valid, o_last;
    logic [7:0] o_tab;
    logic [3:0] o_cnt;

    assign o_abc   = sel ? abc3 : abc1;
    assign o_idx   = sel ? idx3 : idx1;
    assign o_busy  = sel ? busy3 : busy1;
    assign o_done  = sel ? done3 : done1;
    assign o_valid = sel ? valid3 : valid1;
    assign o_last  = sel ? last3 : last1;
    assign o_tab   = sel ? tab3 : tab1;
    assign o_cnt   = sel ? cnt3 : cnt1;

    task automatic check_all_zero(input string name);
        total++;
        if ({o_abc, o_busy, o_done, o_tab, o_cnt, o_valid, o_idx, o_last} !== 23'd0) begin
            bad++;
            $display("FAIL %s: abc=%0d busy=%0b done=%0b tab=%h cnt=%0d v=%0b idx=%0d last=%0b, all 0 required",
                     name, o_abc, o_busy, o_done, o_tab, o_cnt, o_valid, o_idx, o_last);
        end
    endtask

    // Full operation: start, scan, emit with optional back-pressure, done, idle hold.
    task automatic run_scan(input int settle, input bit rnd_ready, input int hold0,
                            input bit poke_start);
        int n;
        int q[$];
        int nz;
        int emit_cyc;
        bit prev_stall;
        logic [2:0] prev_idx;
        bit v;
        n = 8 * (settle + 1);
        for (int i = 0; i < 8; i++) if (!func[i]) q.push_back(i);
        nz = q.size();
        @(negedge clk);
        start = 1'b1;
        ready = 1'b0;
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < n; k++) begin
            total++;
            if (o_busy !== 1'b1 || o_abc !== 3'(k / (settle + 1)) || o_valid !== 1'b0 ||
                o_done !== 1'b0) begin
                bad++;
                $display("FAIL scan_cycle %0d: busy=%0b abc=%0d valid=%0b done=%0b, need 1 %0d 0 0",
                         k, o_busy, o_abc, o_valid, o_done, k / (settle + 1));
            end
            if (poke_start) start = 1'($urandom_range(0, 1));
            ready = 1'($urandom_range(0, 1));
            @(negedge clk);
        end
        total++;
        if (o_tab !== func || o_cnt !== 4'(nz) || o_busy !== 1'b1 || o_abc !== 3'd0) begin
            bad++;
            $display("FAIL scan_result: tab=%h cnt=%0d busy=%0b abc=%0d, need %h %0d 1 0",
                     o_tab, o_cnt, o_busy, o_abc, func, nz);
        end
        emit_cyc = 0;
        prev_stall = 1'b0;
        prev_idx = 3'd0;
        while (!o_done && emit_cyc < 100) begin
            total++;
            if (o_valid !== (q.size() > 0) || o_busy !== 1'b1) begin
                bad++;
                $display("FAIL emit_valid cyc %0d: valid=%0b busy=%0b, need %0b 1",
                         emit_cyc, o_valid, o_busy, q.size() > 0);
            end
            if (o_valid === 1'b1 && q.size() > 0) begin
                total++;
                if (o_idx !== 3'(q[0]) || o_last !== (q.size() == 1) ||
                    (prev_stall && o_idx !== prev_idx)) begin
                    bad++;
                    $display("FAIL emit_index cyc %0d: idx=%0d last=%0b, need %0d %0b",
                             emit_cyc, o_idx, o_last, q[0], q.size() == 1);
                end
            end else begin
                total++;
                if (o_last !== 1'b0 || o_idx !== 3'd0) begin
                    bad++;
                    $display("FAIL emit_idle_outs: idx=%0d last=%0b, need 0 0", o_idx, o_last);
                end
            end
            if (emit_cyc < hold0) ready = 1'b0;
            else ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            v = o_valid;
            if (v && ready && q.size() > 0) void'(q.pop_front());
            prev_stall = v && !ready;
            prev_idx = o_idx;
            if (poke_start) start = 1'($urandom_range(0, 1));
            emit_cyc++;
            @(negedge clk);
        end
        total++;
        if (o_done !== 1'b1 || o_busy !== 1'b0 || q.size() != 0) begin
            bad++;
            $display("FAIL done_pulse: done=%0b busy=%0b left=%0d, need 1 0 0",
                     o_done, o_busy, q.size());
        end
        if (!rnd_ready) begin
            total++;
            if (emit_cyc != ((nz == 0) ? 1 : hold0 + nz)) begin
                bad++;
                $display("FAIL emit_length: %0d cycles, need %0d",
                         emit_cyc, (nz == 0) ? 1 : hold0 + nz);
            end
        end
        start = 1'b0;
        ready = 1'b0;
        @(negedge clk);
        total++;
        if (o_done !== 1'b0 || o_busy !== 1'b0) begin
            bad++;
            $display("FAIL done_width: done=%0b busy=%0b, need 0 0", o_done, o_busy);
        end
        repeat (3) @(negedge clk);
        total++;
        if (o_tab !== func || o_cnt !== 4'(nz) || o_abc !== 3'd0) begin
            bad++;
            $display("FAIL idle_hold: tab=%h cnt=%0d abc=%0d, need %h %0d 0",
                     o_tab, o_cnt, o_abc, func, nz);
        end
    endtask

    task automatic test_reset();
        sel = 1'b0;
        reset = 1'b1;
        start = 1'b0;
        ready = 1'b0;
        func = 8'h00;
        repeat (2) @(negedge clk);
        check_all_zero("reset_dut1");
        sel = 1'b1;
        check_all_zero("reset_dut3");
        sel = 1'b0;
        reset = 1'b0;
    endtask

    task automatic test_known_function();
        sel = 1'b0;
        func = 8'h35;
        run_scan(1, 1'b0, 0, 1'b0);
    endtask

    task automatic test_all_ones();
        sel = 1'b0;
        func = 8'hFF;
        run_scan(1, 1'b0, 0, 1'b0);
    endtask

    task automatic test_all_zeros_stall();
        sel = 1'b0;
        func = 8'h00;
        run_scan(1, 1'b0, 5, 1'b0);
    endtask

    task automatic test_random();
        sel = 1'b0;
        for (int t = 0; t < 6; t++) begin
            func = 8'($urandom);
            run_scan(1, 1'b1, int'($urandom_range(0, 3)), 1'b1);
        end
    endtask

    task automatic test_settle3();
        sel = 1'b1;
        func = 8'($urandom);
        run_scan(3, 1'b0, 0, 1'b0);
        func = 8'($urandom);
        run_scan(3, 1'b1, 2, 1'b1);
        sel = 1'b0;
    endtask

    task automatic test_reset_mid_scan();
        int seen;
        sel = 1'b0;
        func = 8'hA6;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (8) @(negedge clk);
        total++;
        if (o_abc !== 3'd4) begin
            bad++;
            $display("FAIL mid_scan_idx: abc=%0d, need 4", o_abc);
        end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check_all_zero("reset_mid_scan");
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            if (o_done || o_busy) seen++;
            @(negedge clk);
        end
        total++;
        if (seen != 0) begin
            bad++;
            $display("FAIL post_reset_quiet: %0d active cycles, need 0", seen);
        end
        run_scan(1, 1'b0, 0, 1'b0);
    endtask

    task automatic test_start_reset_idle();
        sel = 1'b0;
        @(negedge clk);
        start = 1'b1;
        reset = 1'b1;
        @(negedge clk);
        start = 1'b0;
        reset = 1'b0;
        check_all_zero("start_with_reset");
        @(negedge clk);
        total++;
        if (o_busy !== 1'b0 || o_abc !== 3'd0) begin
            bad++;
            $display("FAIL stays_idle: busy=%0b abc=%0d, need 0 0", o_busy, o_abc);
        end
    endtask

    task automatic test_back_to_back();
        sel = 1'b0;
        func = 8'h5A;
        run_scan(1, 1'b1, 0, 1'b0);
        func = 8'h81;
        run_scan(1, 1'b0, 1, 1'b0);
    endtask

    initial begin
        total = 0;
        bad = 0;
        sel = 1'b0;
        reset = 1'b1;
        start = 1'b0;
        ready = 1'b0;
        func = 8'h00;
        test_reset();
        test_known_function();
        test_all_ones();
        test_all_zeros_stall();
        test_random();
        test_settle3();
        test_reset_mid_scan();
        test_start_reset_idle();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
